// File: rtl/spi_pkg.sv
// Shared types and helpers for the multi-slave SPI master.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SS_SETUP,
    ST_CPHA_DLY,
    ST_P0,
    ST_P1,
    ST_SS_TURNOFF
  } spi_state_t;

  localparam int unsigned MAX_DATA_W = 32;
  localparam int unsigned MAX_IDX_W  = $clog2(MAX_DATA_W);

  // Select-index width; a single slave still needs one bit.
  function automatic int unsigned ss_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Reverse the low w bits of x; bits at and above w are returned as zero.
  function automatic logic [MAX_DATA_W-1:0] bit_rev(input logic [MAX_DATA_W-1:0] x,
                                                    input int unsigned w);
    logic [MAX_DATA_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < MAX_DATA_W; i++) begin
      if (i < w) r[MAX_IDX_W'(i)] = x[MAX_IDX_W'(w - 1 - i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/spi_half_period_cnt.sv
// Half-period timer: ticks on the last clk cycle of each D = dvsr+1 cycle phase.
module spi_half_period_cnt #(
  parameter int unsigned DVSR_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_clr,
  input  logic              i_en,
  input  logic [DVSR_W-1:0] i_dvsr,
  output logic              o_tick_c
);

  logic [DVSR_W-1:0] r_cnt;

  assign o_tick_c = i_en && (r_cnt == i_dvsr);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_tick_c ? '0 : r_cnt + DVSR_W'(1);
    end
  end

endmodule

// File: rtl/spi_master_multi.sv
// Parametrised SPI master: any CPOL/CPHA mode, MSB/LSB first, NUM_SS selects
// with setup/turn-off spacing and optional select hold between transfers.
module spi_master_multi
  import spi_pkg::*;
#(
  parameter  int unsigned DATA_W = 8,
  parameter  int unsigned NUM_SS = 4,
  parameter  int unsigned DVSR_W = 16,
  localparam int unsigned SS_W   = ss_width(NUM_SS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] din,
  input  logic [DVSR_W-1:0] dvsr,
  input  logic              start,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  input  logic              hold_ss,
  input  logic [SS_W-1:0]   ss_sel,
  output logic [DATA_W-1:0] dout,
  output logic              spi_done_tick,
  output logic              ready,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_SS-1:0] ss_n
);

  localparam int unsigned      CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  spi_state_t        r_state, w_next;
  logic [DATA_W-1:0] r_tx, r_rx, r_dout;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [DVSR_W-1:0] r_dvsr;
  logic [SS_W-1:0]   r_sel, r_held_sel;
  logic              r_cpol, r_cpha, r_lsb, r_hold, r_held;
  logic [NUM_SS-1:0] r_ss_n;
  logic              r_sclk, r_mosi, r_done, r_ready;

  logic              w_tick, w_cnt_en;
  logic              w_accept, w_sample, w_bit_end, w_last, w_phase;
  logic              w_held_hit, w_sel_ok, w_rsel_ok, w_cpha_eff, w_cpol_eff;
  logic [DATA_W-1:0] w_din_ord, w_rx_ord;

  assign w_cnt_en   = (r_state != ST_IDLE);
  assign w_held_hit = r_held && (r_held_sel == ss_sel);
  assign w_sel_ok   = 32'(ss_sel) < NUM_SS;
  assign w_rsel_ok  = 32'(r_sel) < NUM_SS;
  // Mode comes straight from the inputs while idle so sclk tracks cpol there.
  assign w_cpha_eff = (r_state == ST_IDLE) ? cpha : r_cpha;
  assign w_cpol_eff = (r_state == ST_IDLE || w_next == ST_IDLE) ? cpol : r_cpol;
  // LSB-first is handled by reversing at the edges; the shifters always run MSB-first.
  assign w_din_ord  = lsb_first ? DATA_W'(bit_rev(MAX_DATA_W'(din), DATA_W)) : din;
  assign w_rx_ord   = r_lsb ? DATA_W'(bit_rev(MAX_DATA_W'(r_rx), DATA_W)) : r_rx;

  spi_half_period_cnt #(
    .DVSR_W (DVSR_W)
  ) u_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_clr    (!w_cnt_en),
    .i_en     (w_cnt_en),
    .i_dvsr   (r_dvsr),
    .o_tick_c (w_tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:       if (start) w_next = w_held_hit ? (cpha ? ST_CPHA_DLY : ST_P0) : ST_SS_SETUP;
      ST_SS_SETUP:   if (w_tick) w_next = r_cpha ? ST_CPHA_DLY : ST_P0;
      ST_CPHA_DLY:   if (w_tick) w_next = ST_P0;
      ST_P0:         if (w_tick) w_next = ST_P1;
      ST_P1:         if (w_tick) w_next = (r_bit_cnt != LAST_BIT) ? ST_P0 :
                                          (r_hold ? ST_IDLE : ST_SS_TURNOFF);
      ST_SS_TURNOFF: if (w_tick) w_next = ST_IDLE;
      default:       w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_accept  = 1'b0;
    w_sample  = 1'b0;
    w_bit_end = 1'b0;
    w_last    = 1'b0;
    w_phase   = 1'b0;
    w_accept  = (r_state == ST_IDLE) && start;
    w_sample  = (r_state == ST_P0) && w_tick;
    w_bit_end = (r_state == ST_P1) && w_tick;
    w_last    = w_bit_end && (r_bit_cnt == LAST_BIT);
    w_phase   = w_cpha_eff ? (w_next == ST_P0) : (w_next == ST_P1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tx       <= '0;
      r_rx       <= '0;
      r_dout     <= '0;
      r_bit_cnt  <= '0;
      r_dvsr     <= '0;
      r_sel      <= '0;
      r_held_sel <= '0;
      r_cpol     <= 1'b0;
      r_cpha     <= 1'b0;
      r_lsb      <= 1'b0;
      r_hold     <= 1'b0;
      r_held     <= 1'b0;
      r_ss_n     <= '1;
      r_sclk     <= 1'b0;
      r_mosi     <= 1'b0;
      r_done     <= 1'b0;
      r_ready    <= 1'b1;
    end else begin
      r_done  <= w_last;
      r_ready <= (w_next == ST_IDLE);
      r_sclk  <= w_phase ^ w_cpol_eff;
      if (w_accept) begin
        r_tx      <= w_din_ord << 1;
        r_mosi    <= w_din_ord[DATA_W-1];
        r_rx      <= '0;
        r_bit_cnt <= '0;
        r_cpol    <= cpol;
        r_cpha    <= cpha;
        r_lsb     <= lsb_first;
        r_hold    <= hold_ss;
        r_sel     <= ss_sel;
        r_dvsr    <= dvsr;
        // A different target drops any held slave and selects the new one together.
        if (!w_held_hit) begin
          r_held <= 1'b0;
          r_ss_n <= ~(NUM_SS'(w_sel_ok) << ss_sel);
        end
      end
      if (w_sample) r_rx <= {r_rx[DATA_W-2:0], miso};
      if (w_bit_end) begin
        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
        r_mosi    <= r_tx[DATA_W-1];
        r_tx      <= r_tx << 1;
      end
      if (w_last) begin
        r_dout <= w_rx_ord;
        r_mosi <= 1'b0;
        if (r_hold && w_rsel_ok) begin
          r_held     <= 1'b1;
          r_held_sel <= r_sel;
        end else begin
          r_held <= 1'b0;
          r_ss_n <= '1;
        end
      end
    end
  end

  assign dout          = r_dout;
  assign spi_done_tick = r_done;
  assign ready         = r_ready;
  assign sclk          = r_sclk;
  assign mosi          = r_mosi;
  assign ss_n          = r_ss_n;

endmodule

// File: tb/tb_spi_master_multi.sv
// Directed bench for spi_master_multi: 8-bit/4-slave main instance plus
// 16-bit/1-slave and 32-bit/2-slave instances run at dvsr=0.
module tb_spi_master_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors;
  int checks;

  logic        reset_n;
  logic [7:0]  din, dout;
  logic [15:0] dvsr;
  logic        start, cpol, cpha, lsb_first, hold_ss;
  logic [1:0]  ss_sel;
  logic        spi_done_tick, ready, sclk, mosi, miso;
  logic [3:0]  ss_n;
  logic        loop_en;

  // Slave model on ss_n[0]: MSB-first shifter following the configured mode.
  logic [7:0] s_tx, s_rx, slave_word;
  logic       s_miso, s_cpol, s_cpha;
  logic       s_prev_ss   = 1'b1;
  logic       s_prev_sclk = 1'b0;

  assign miso = loop_en ? mosi : s_miso;

  always @(sclk or ss_n[0]) begin
    if (!ss_n[0] && s_prev_ss) begin
      s_tx = slave_word;
      s_rx = 8'h00;
      if (!s_cpha) begin
        s_miso = s_tx[7];
        s_tx   = {s_tx[6:0], 1'b0};
      end
    end else if (!ss_n[0] && (sclk != s_prev_sclk)) begin
      if ((sclk != s_cpol) == !s_cpha) begin
        s_rx = {s_rx[6:0], mosi};
      end else begin
        s_miso = s_tx[7];
        s_tx   = {s_tx[6:0], 1'b0};
      end
    end
    s_prev_ss   = ss_n[0];
    s_prev_sclk = sclk;
  end

  spi_master_multi #(.DATA_W(8), .NUM_SS(4), .DVSR_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .din(din), .dvsr(dvsr), .start(start),
    .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first), .hold_ss(hold_ss),
    .ss_sel(ss_sel), .dout(dout), .spi_done_tick(spi_done_tick), .ready(ready),
    .sclk(sclk), .mosi(mosi), .miso(miso), .ss_n(ss_n)
  );

  logic [15:0] b_din, b_dout;
  logic        b_start, b_done, b_ready, b_sclk, b_mosi;
  logic [0:0]  b_ss_sel, b_ss_n;

  spi_master_multi #(.DATA_W(16), .NUM_SS(1), .DVSR_W(16)) dut16 (
    .clk(clk), .reset_n(reset_n), .din(b_din), .dvsr(16'd0), .start(b_start),
    .cpol(1'b0), .cpha(1'b0), .lsb_first(1'b0), .hold_ss(1'b0),
    .ss_sel(b_ss_sel), .dout(b_dout), .spi_done_tick(b_done), .ready(b_ready),
    .sclk(b_sclk), .mosi(b_mosi), .miso(b_mosi), .ss_n(b_ss_n)
  );

  logic [31:0] c_din, c_dout;
  logic        c_start, c_done, c_ready, c_sclk, c_mosi;
  logic [0:0]  c_ss_sel;
  logic [1:0]  c_ss_n;

  spi_master_multi #(.DATA_W(32), .NUM_SS(2), .DVSR_W(16)) dut32 (
    .clk(clk), .reset_n(reset_n), .din(c_din), .dvsr(16'd0), .start(c_start),
    .cpol(1'b0), .cpha(1'b0), .lsb_first(1'b0), .hold_ss(1'b0),
    .ss_sel(c_ss_sel), .dout(c_dout), .spi_done_tick(c_done), .ready(c_ready),
    .sclk(c_sclk), .mosi(c_mosi), .miso(c_mosi), .ss_n(c_ss_n)
  );

  task automatic start_main(input logic [7:0] d, input logic pol, input logic pha,
                            input logic lsb, input logic hold, input logic [1:0] sel);
    int n;
    n = 0;
    @(negedge clk);
    while (!ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL start_ready_timeout got=%b exp=1", ready);
    end
    din = d; cpol = pol; cpha = pha; lsb_first = lsb; hold_ss = hold; ss_sel = sel;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Cycles from accept edge to done tick (-1 on timeout), sclk rises, OR of ss_n samples.
  task automatic wait_done(input int limit, output int cyc, output int rises,
                           output logic [3:0] ss_hi);
    logic prev;
    logic got;
    cyc = 0; rises = 0; ss_hi = '0; prev = sclk; got = 1'b0;
    while (!got && cyc < limit) begin
      @(posedge clk);
      #1;
      cyc++;
      if (sclk && !prev) rises++;
      prev  = sclk;
      ss_hi = ss_hi | ss_n;
      got   = spi_done_tick;
    end
    if (!got) cyc = -1;
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    #1;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (ss_n !== 4'b1111) begin errors++; $display("FAIL reset_ss_n got=%b exp=1111", ss_n); end
    checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk got=%b exp=0", sclk); end
    checks++; if (mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi got=%b exp=0", mosi); end
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout got=%h exp=00", dout); end
    checks++; if (spi_done_tick !== 1'b0) begin errors++; $display("FAIL reset_tick got=%b exp=0", spi_done_tick); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", ready); end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_basic();
    int cyc, rises;
    logic [3:0] sh;
    loop_en = 1'b1; dvsr = 16'd1;
    start_main(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    checks++; if (ss_n !== 4'b1110) begin errors++; $display("FAIL basic_ss_n got=%b exp=1110", ss_n); end
    wait_done(100, cyc, rises, sh);
    checks++; if (cyc != 34) begin errors++; $display("FAIL basic_latency got=%0d exp=34", cyc); end
    checks++; if (rises != 8) begin errors++; $display("FAIL basic_sclk_rises got=%0d exp=8", rises); end
    checks++; if (dout !== 8'hA5) begin errors++; $display("FAIL basic_dout got=%h exp=a5", dout); end
    @(posedge clk);
    #1;
    checks++; if (spi_done_tick !== 1'b0) begin errors++; $display("FAIL basic_tick_width got=%b exp=0", spi_done_tick); end
  endtask

  task automatic test_modes();
    int cyc, rises, n;
    logic [3:0] sh;
    logic pol, pha;
    loop_en = 1'b0; dvsr = 16'd1; slave_word = 8'h3C;
    for (int m = 0; m < 4; m++) begin
      pol = m[1]; pha = m[0];
      n = 0;
      while (!ready && n < 100) begin @(posedge clk); n++; end
      @(negedge clk);
      cpol = pol; cpha = pha; s_cpol = pol; s_cpha = pha;
      @(posedge clk);
      #1;
      checks++; if (sclk !== pol) begin errors++; $display("FAIL mode%0d_sclk_idle got=%b exp=%b", m, sclk, pol); end
      start_main(8'hC3, pol, pha, 1'b0, 1'b0, 2'd0);
      wait_done(100, cyc, rises, sh);
      checks++; if (cyc != (pha ? 36 : 34)) begin errors++; $display("FAIL mode%0d_latency got=%0d exp=%0d", m, cyc, pha ? 36 : 34); end
      checks++; if (dout !== 8'h3C) begin errors++; $display("FAIL mode%0d_dout got=%h exp=3c", m, dout); end
      checks++; if (s_rx !== 8'hC3) begin errors++; $display("FAIL mode%0d_slave_rx got=%h exp=c3", m, s_rx); end
      checks++; if (rises != 8) begin errors++; $display("FAIL mode%0d_sclk_rises got=%0d exp=8", m, rises); end
      @(posedge clk);
      #1;
      checks++; if (sclk !== pol) begin errors++; $display("FAIL mode%0d_sclk_after got=%b exp=%b", m, sclk, pol); end
    end
  endtask

  task automatic test_lsb_first();
    int cyc, rises;
    logic [3:0] sh;
    loop_en = 1'b0; dvsr = 16'd1; s_cpol = 1'b0; s_cpha = 1'b0;
    slave_word = 8'h01;
    start_main(8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
    checks++; if (mosi !== 1'b1) begin errors++; $display("FAIL lsb_first_bit got=%b exp=1", mosi); end
    wait_done(100, cyc, rises, sh);
    checks++; if (dout !== 8'h80) begin errors++; $display("FAIL lsb_dout got=%h exp=80", dout); end
    checks++; if (s_rx !== 8'h80) begin errors++; $display("FAIL lsb_slave_rx got=%h exp=80", s_rx); end
  endtask

  task automatic test_hold();
    int cyc, rises;
    logic [3:0] sh;
    loop_en = 1'b1; dvsr = 16'd1;
    start_main(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2);
    wait_done(100, cyc, rises, sh);
    checks++; if (cyc != 34) begin errors++; $display("FAIL hold1_latency got=%0d exp=34", cyc); end
    @(posedge clk);
    #1;
    checks++; if (ss_n !== 4'b1011) begin errors++; $display("FAIL hold_idle_ss_n got=%b exp=1011", ss_n); end
    start_main(8'h96, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2);
    wait_done(100, cyc, rises, sh);
    checks++; if (cyc != 32) begin errors++; $display("FAIL hold2_latency got=%0d exp=32", cyc); end
    checks++; if (sh[2] !== 1'b0) begin errors++; $display("FAIL hold2_ss2_rose got=%b exp=0", sh[2]); end
    checks++; if (dout !== 8'h96) begin errors++; $display("FAIL hold2_dout got=%h exp=96", dout); end
    start_main(8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1);
    checks++; if (ss_n !== 4'b1101) begin errors++; $display("FAIL hold_switch_ss_n got=%b exp=1101", ss_n); end
    wait_done(100, cyc, rises, sh);
    checks++; if (cyc != 34) begin errors++; $display("FAIL hold3_latency got=%0d exp=34", cyc); end
    checks++; if (ss_n !== 4'b1111) begin errors++; $display("FAIL hold3_release got=%b exp=1111", ss_n); end
  endtask

  task automatic test_reset_mid();
    int ticks;
    loop_en = 1'b1; dvsr = 16'd1;
    start_main(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    repeat (20) @(posedge clk);
    #1;
    checks++; if (sclk !== 1'b1) begin errors++; $display("FAIL rstmid_pre_sclk got=%b exp=1", sclk); end
    reset_n = 1'b0;
    #1;
    checks++; if (ss_n !== 4'b1111) begin errors++; $display("FAIL rstmid_ss_n got=%b exp=1111", ss_n); end
    checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL rstmid_sclk got=%b exp=0", sclk); end
    checks++; if (dout !== 8'h00) begin errors++; $display("FAIL rstmid_dout got=%h exp=00", dout); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got=%b exp=1", ready); end
    ticks = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (spi_done_tick) ticks++;
    end
    checks++; if (ticks != 0) begin errors++; $display("FAIL rstmid_ticks got=%0d exp=0", ticks); end
  endtask

  task automatic test_ignore_start();
    int ticks;
    loop_en = 1'b1; dvsr = 16'd1;
    start_main(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    din = 8'hFF; start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    ticks = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (spi_done_tick) ticks++;
    end
    checks++; if (ticks != 1) begin errors++; $display("FAIL ignore_ticks got=%0d exp=1", ticks); end
    checks++; if (dout !== 8'h5A) begin errors++; $display("FAIL ignore_dout got=%h exp=5a", dout); end
  endtask

  task automatic test_wide();
    int cyc;
    logic got, lowseen;
    // 16-bit, valid slave 0
    @(negedge clk);
    b_din = 16'h1234; b_ss_sel = 1'b0; b_start = 1'b1;
    @(posedge clk);
    #1;
    b_start = 1'b0;
    checks++; if (b_ss_n !== 1'b0) begin errors++; $display("FAIL w16_ss_n got=%b exp=0", b_ss_n); end
    cyc = 0; got = 1'b0;
    while (!got && cyc < 100) begin @(posedge clk); #1; cyc++; got = b_done; end
    if (!got) cyc = -1;
    checks++; if (cyc != 33) begin errors++; $display("FAIL w16_latency got=%0d exp=33", cyc); end
    checks++; if (b_dout !== 16'h1234) begin errors++; $display("FAIL w16_dout got=%h exp=1234", b_dout); end
    // 16-bit, out-of-range select
    repeat (4) @(posedge clk);
    @(negedge clk);
    b_din = 16'hBEEF; b_ss_sel = 1'b1; b_start = 1'b1;
    @(posedge clk);
    #1;
    b_start = 1'b0;
    cyc = 0; got = 1'b0; lowseen = (b_ss_n === 1'b0);
    while (!got && cyc < 100) begin
      @(posedge clk); #1; cyc++;
      if (b_ss_n === 1'b0) lowseen = 1'b1;
      got = b_done;
    end
    if (!got) cyc = -1;
    checks++; if (lowseen !== 1'b0) begin errors++; $display("FAIL badsel_ss_low got=%b exp=0", lowseen); end
    checks++; if (cyc != 33) begin errors++; $display("FAIL badsel_latency got=%0d exp=33", cyc); end
    checks++; if (b_dout !== 16'hBEEF) begin errors++; $display("FAIL badsel_dout got=%h exp=beef", b_dout); end
    // 32-bit
    @(negedge clk);
    c_din = 32'hDEADBEEF; c_ss_sel = 1'b0; c_start = 1'b1;
    @(posedge clk);
    #1;
    c_start = 1'b0;
    checks++; if (c_ss_n !== 2'b10) begin errors++; $display("FAIL w32_ss_n got=%b exp=10", c_ss_n); end
    cyc = 0; got = 1'b0;
    while (!got && cyc < 200) begin @(posedge clk); #1; cyc++; got = c_done; end
    if (!got) cyc = -1;
    checks++; if (cyc != 65) begin errors++; $display("FAIL w32_latency got=%0d exp=65", cyc); end
    checks++; if (c_dout !== 32'hDEADBEEF) begin errors++; $display("FAIL w32_dout got=%h exp=deadbeef", c_dout); end
  endtask

  initial begin
    errors = 0; checks = 0;
    din = '0; dvsr = 16'd1; start = 1'b0; cpol = 1'b0; cpha = 1'b0;
    lsb_first = 1'b0; hold_ss = 1'b0; ss_sel = '0; loop_en = 1'b1;
    s_cpol = 1'b0; s_cpha = 1'b0; slave_word = 8'h00; s_miso = 1'b0;
    s_tx = 8'h00; s_rx = 8'h00;
    b_din = '0; b_start = 1'b0; b_ss_sel = '0;
    c_din = '0; c_start = 1'b0; c_ss_sel = '0;
    test_reset();
    test_basic();
    test_modes();
    test_lsb_first();
    test_hold();
    test_reset_mid();
    test_ignore_start();
    test_wide();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
